// File: rtl/ir_key_pkg.sv
// Shared definitions for the IR key controller: FSM states, NEC key codes
// and the key-to-BCD digit lookup.
package ir_key_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [7:0] KEY_OK  = 8'h40;
   localparam logic [7:0] KEY_CLR = 8'h44;

   // Returns {is_digit, bcd}; bcd is 0 for non-digit keys.
   function automatic logic [4:0] key_to_digit(input logic [7:0] key);
      logic [4:0] r;
      r = 5'h00;
      case (key)
         8'h16:   r = {1'b1, 4'd0};
         8'h0C:   r = {1'b1, 4'd1};
         8'h18:   r = {1'b1, 4'd2};
         8'h5E:   r = {1'b1, 4'd3};
         8'h08:   r = {1'b1, 4'd4};
         8'h1C:   r = {1'b1, 4'd5};
         8'h5A:   r = {1'b1, 4'd6};
         8'h42:   r = {1'b1, 4'd7};
         8'h52:   r = {1'b1, 4'd8};
         8'h4A:   r = {1'b1, 4'd9};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ir_key_ctrl_chk.sv
// Combinational NEC frame validation and key classification.
module ir_frame_chk
   import ir_key_pkg::*;
#(
   parameter logic [7:0] CUSTOM_CODE = 8'h00
) (
   input  logic [31:0] frame,
   output logic        valid,
   output logic        is_digit,
   output logic        is_ok,
   output logic        is_clr,
   output logic [3:0]  bcd
);

   logic [4:0] dig;

   assign dig   = key_to_digit(frame[15:8]);
   assign valid = (frame[31:24] == CUSTOM_CODE) &&
                  (frame[23:16] == ~frame[31:24]) &&
                  (frame[15:8]  == ~frame[7:0]);

   assign is_digit = valid & dig[4];
   assign is_ok    = valid & (frame[15:8] == KEY_OK);
   assign is_clr   = valid & (frame[15:8] == KEY_CLR);
   assign bcd      = dig[3:0];

endmodule

// File: rtl/ir_key_ctrl.sv
// IR key command controller: validates frames, edits a 6-digit BCD entry,
// commits/clears/times it out, and drives the registered display path.
module ir_key_ctrl
   import ir_key_pkg::*;
#(
   parameter logic [7:0] CUSTOM_CODE = 8'h00,
   parameter int         TIMEOUT_CYC = 250_000_000,
   parameter int         TMR_W       = 28
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_frame,
   input  logic        i_frame_vld,
   output logic [23:0] o_disp_bcd,
   output logic [5:0]  o_disp_dp,
   output logic [23:0] o_value,
   output logic        o_commit,
   output logic        o_err,
   output logic        o_editing
);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [23:0]       buf_q, buf_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [23:0]       value_q, value_d;
   logic [23:0]       disp_bcd_q, disp_bcd_d;
   logic [5:0]        disp_dp_q, disp_dp_d;
   logic              commit_q, err_q;

   logic              f_valid, f_digit, f_ok, f_clr;
   logic [3:0]        f_bcd;
   logic              hit_digit, hit_ok, hit_clr;

   ir_frame_chk #(.CUSTOM_CODE(CUSTOM_CODE)) u_chk (
      .frame    (i_frame),
      .valid    (f_valid),
      .is_digit (f_digit),
      .is_ok    (f_ok),
      .is_clr   (f_clr),
      .bcd      (f_bcd)
   );

   assign hit_digit = i_frame_vld & f_digit;
   assign hit_ok    = i_frame_vld & f_ok;
   assign hit_clr   = i_frame_vld & f_clr;

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      value_d = value_q;
      case (state_q)
         IDLE: begin
            if (hit_digit) begin
               buf_d   = {20'h0, f_bcd};
               cnt_d   = 3'd1;
               tmr_d   = '0;
               state_d = EDIT;
            end
         end
         EDIT: begin
            // A mapped key always wins over a coincident timer expiry.
            if (hit_digit) begin
               if (cnt_q < 3'd6) begin
                  buf_d = {buf_q[19:0], f_bcd};
                  cnt_d = cnt_q + 3'd1;
               end
               tmr_d = '0;
            end else if (hit_clr) begin
               buf_d = '0;
               cnt_d = '0;
               tmr_d = '0;
            end else if (hit_ok) begin
               value_d = buf_q;
               buf_d   = '0;
               cnt_d   = '0;
               tmr_d   = '0;
               state_d = COMMIT;
            end else if (tmr_q == TMR_LAST) begin
               buf_d   = '0;
               cnt_d   = '0;
               tmr_d   = '0;
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Display is registered from next-state values so it lines up with o_editing.
   always_comb begin
      disp_bcd_d = value_d;
      disp_dp_d  = '0;
      if (state_d == EDIT) begin
         disp_bcd_d = buf_d;
         if (cnt_d != 3'd0)
            disp_dp_d = 6'b000001 << (cnt_d - 3'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         cnt_q      <= '0;
         tmr_q      <= '0;
         value_q    <= '0;
         disp_bcd_q <= '0;
         disp_dp_q  <= '0;
         commit_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         cnt_q      <= cnt_d;
         tmr_q      <= tmr_d;
         value_q    <= value_d;
         disp_bcd_q <= disp_bcd_d;
         disp_dp_q  <= disp_dp_d;
         commit_q   <= (state_q == COMMIT);
         err_q      <= i_frame_vld & ~f_valid;
      end
   end

   assign o_disp_bcd = disp_bcd_q;
   assign o_disp_dp  = disp_dp_q;
   assign o_value    = value_q;
   assign o_commit   = commit_q;
   assign o_err      = err_q;
   assign o_editing  = (state_q == EDIT);

endmodule
